gate_sweep_checker: RTL and testbench

Parametrised, self-checking exhaustive stimulus engine for the combinational gate blocks. On `start` it walks an N-bit input vector through all 2^N combinations, holds each vector for a programmable settle time, samples the device-under-test response and compares it against a golden reduction (AND/OR/XOR/NAND) over the enabled inputs. It also counts mismatches and captures the first failing vector. It sits between the gate-level circuits and the simulation top, replacing free-running toggle stimulus with a bounded, reportable sweep.

---
 rtl/gate_sweep_checker.sv | 137 +++++++++++++
 tb/tb_gate_sweep_checker.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: exhaustive stimulus engine for combinational gate blocks.
// Walks an N-bit vector through all 2^N values, holds each for SETTLE cycles,
// then compares the DUT response against a golden AND/OR/XOR/NAND reduction
// over the enabled inputs. It counts mismatches and captures the first failing vector.
module gate_sweep_checker #(
  parameter int N      = 9,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       mode,
  input  logic [N-1:0]     en,
  input  logic             dut_resp,
  output logic [N-1:0]     vec_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [N-1:0]     first_err_vec,
  output logic             first_err_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0]   TIMER_LOAD = 8'(SETTLE - 1);
  localparam logic [N-1:0] VEC_LAST   = '1;

  state_t           state_q;
  logic [7:0]       timer_q;
  logic [1:0]       modeHeld_q;
  logic [N-1:0]     enHeld_q;

  logic [N-1:0]     maskedAnd_d;
  logic [N-1:0]     maskedOr_d;
  logic             expected_d;
  logic             mismatch_d;
  logic [CNT_W-1:0] errCnt_d;

  // Golden reduction over the latched enables; disabled inputs take the op identity,
  // and the error count advances on a mismatch but stops at all-ones
  always_comb begin
    maskedAnd_d = vec_out | ~enHeld_q;
    maskedOr_d  = vec_out & enHeld_q;
    expected_d  = 1'b0;
    case (modeHeld_q)
      2'b00:   expected_d = &maskedAnd_d;
      2'b01:   expected_d = |maskedOr_d;
      2'b10:   expected_d = ^maskedOr_d;
      default: expected_d = ~(&maskedAnd_d);
    endcase
    mismatch_d = (dut_resp != expected_d);
    errCnt_d   = err_cnt;
    if (mismatch_d && (err_cnt != '1)) begin
      errCnt_d = err_cnt + CNT_W'(1);
    end
  end

  // Sweep controller: every output is a register updated here alongside the state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      timer_q         <= '0;
      modeHeld_q      <= '0;
      enHeld_q        <= '0;
      vec_out         <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_cnt         <= '0;
      first_err_vec   <= '0;
      first_err_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q         <= APPLY;
            timer_q         <= TIMER_LOAD;
            modeHeld_q      <= mode;
            enHeld_q        <= en;
            vec_out         <= '0;
            busy            <= 1'b1;
            pass            <= 1'b0;
            err_cnt         <= '0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
          end
        end
        APPLY: begin
          if (abort) begin
            state_q <= IDLE;
            busy    <= 1'b0;
          end else if (timer_q == 8'd0) begin
            state_q <= CHECK;
          end else begin
            timer_q <= timer_q - 8'd1;
          end
        end
        CHECK: begin
          if (abort) begin
            state_q <= IDLE;
            busy    <= 1'b0;
          end else begin
            err_cnt <= errCnt_d;
            if (mismatch_d && !first_err_valid) begin
              first_err_vec   <= vec_out;
              first_err_valid <= 1'b1;
            end
            if (vec_out == VEC_LAST) begin
              state_q <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= (errCnt_d == '0);
            end else begin
              vec_out <= vec_out + N'(1);
              timer_q <= TIMER_LOAD;
              state_q <= APPLY;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Testbench for gate_sweep_checker: two instances with different N/SETTLE/CNT_W,
// driven with directed and randomized sweeps and checked against a behavioural model.
module tb_gate_sweep_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [1:0]  mode;
  logic [15:0] en;
  int          sel;
  int          curN;
  int          curS;
  int          curW;
  logic        respTable [16];

  int totalCnt = 0;
  int badCnt   = 0;

  logic       aStart, aAbort, aResp, aBusy, aDone, aPass, aFval;
  logic [2:0] aVec, aFev;
  logic [15:0] aErr;
  logic       bStart, bAbort, bResp, bBusy, bDone, bPass, bFval;
  logic [1:0] bVec, bFev;
  logic [1:0] bErr;

  logic [15:0] obsVec, obsErr, obsFev;
  logic        obsBusy, obsDone, obsPass, obsFval;

  assign aStart = start && (sel == 0);
  assign aAbort = abort && (sel == 0);
  assign bStart = start && (sel == 1);
  assign bAbort = abort && (sel == 1);
  assign aResp  = respTable[aVec];
  assign bResp  = respTable[bVec];

  gate_sweep_checker #(.N(3), .SETTLE(1), .CNT_W(16)) dutA (
    .clk(clk), .rst_n(rst_n), .start(aStart), .abort(aAbort), .mode(mode),
    .en(en[2:0]), .dut_resp(aResp), .vec_out(aVec), .busy(aBusy), .done(aDone),
    .pass(aPass), .err_cnt(aErr), .first_err_vec(aFev), .first_err_valid(aFval)
  );

  gate_sweep_checker #(.N(2), .SETTLE(3), .CNT_W(2)) dutB (
    .clk(clk), .rst_n(rst_n), .start(bStart), .abort(bAbort), .mode(mode),
    .en(en[1:0]), .dut_resp(bResp), .vec_out(bVec), .busy(bBusy), .done(bDone),
    .pass(bPass), .err_cnt(bErr), .first_err_vec(bFev), .first_err_valid(bFval)
  );

  always #5 clk = ~clk;

  // Route the selected instance's outputs onto common observation signals
  always_comb begin
    obsVec  = (sel == 1) ? 16'(bVec) : 16'(aVec);
    obsErr  = (sel == 1) ? 16'(bErr) : aErr;
    obsFev  = (sel == 1) ? 16'(bFev) : 16'(aFev);
    obsBusy = (sel == 1) ? bBusy : aBusy;
    obsDone = (sel == 1) ? bDone : aDone;
    obsPass = (sel == 1) ? bPass : aPass;
    obsFval = (sel == 1) ? bFval : aFval;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic selectDut(input int s);
    sel  = s;
    curN = (s == 1) ? 2 : 3;
    curS = (s == 1) ? 3 : 1;
    curW = (s == 1) ? 2 : 16;
    #1;
  endtask

  // Reference reduction: count enabled ones and decide from the op's meaning
  function automatic int golden(input int m, input int e, input int v, input int n);
    int ones = 0;
    int used = 0;
    for (int i = 0; i < n; i++) begin
      if (((e >> i) & 1) == 1) begin
        used++;
        ones += (v >> i) & 1;
      end
    end
    case (m)
      0:       return (ones == used) ? 1 : 0;
      1:       return (ones > 0) ? 1 : 0;
      2:       return ones % 2;
      default: return (ones == used) ? 0 : 1;
    endcase
  endfunction

  // Response table: 0 correct, 1 parity of all bits, 2 stuck at 1, 3 always wrong, 4 random
  task automatic fillResp(input int kind);
    int g;
    int val;
    for (int v = 0; v < 16; v++) begin
      g = golden(int'(mode), int'(en), v, curN);
      case (kind)
        0:       val = g;
        1:       val = $countones(v & ((1 << curN) - 1)) % 2;
        2:       val = 1;
        3:       val = 1 - g;
        default: val = int'($urandom_range(0, 1));
      endcase
      respTable[v] = 1'(val);
    end
  endtask

  // One sweep on the selected instance; abortVec < 0 means run to completion
  task automatic runSweep(input string tag, input int abortVec, input int abortPhase,
                          input bit abortWithStart);
    int total  = 1 << curN;
    int maxCnt = (curW >= 31) ? 32'h7fffffff : ((1 << curW) - 1);
    int lim    = (abortVec >= 0) ? abortVec : total;
    int errs   = 0;
    int firstV = 0;
    bit gotFirst = 1'b0;
    int expErr;
    int mMode = int'(mode);
    int mEn   = int'(en);
    for (int v = 0; v < lim; v++) begin
      if (int'(respTable[v]) != golden(mMode, mEn, v, curN)) begin
        errs++;
        if (!gotFirst) begin
          gotFirst = 1'b1;
          firstV   = v;
        end
      end
    end
    expErr = (errs > maxCnt) ? maxCnt : errs;

    start = 1'b1;
    abort = abortWithStart;
    tick();
    start = 1'b0;
    abort = 1'b0;
    mode  = 2'($urandom_range(0, 3));
    en    = 16'($urandom);
    totalCnt++;
    if (obsBusy !== 1'b1 || obsErr !== 16'd0 || obsFval !== 1'b0 || obsVec !== 16'd0) begin
      badCnt++;
      $display("[TB] FAIL %s start-clear got busy=%b err=%0d fval=%b vec=%0d want busy=1 err=0 fval=0 vec=0",
               tag, obsBusy, obsErr, obsFval, obsVec);
    end

    for (int v = 0; v < total; v++) begin
      for (int c = 0; c <= curS; c++) begin
        if (v == abortVec && c == abortPhase) begin
          abort = 1'b1;
          tick();
          abort = 1'b0;
          totalCnt++;
          if (obsBusy !== 1'b0 || obsDone !== 1'b0 || obsVec !== 16'(v) || obsPass !== 1'b0) begin
            badCnt++;
            $display("[TB] FAIL %s abort-state got busy=%b done=%b vec=%0d pass=%b want busy=0 done=0 vec=%0d pass=0",
                     tag, obsBusy, obsDone, obsVec, obsPass, v);
          end
          totalCnt++;
          if (obsErr !== 16'(expErr) || obsFval !== gotFirst || obsFev !== 16'(firstV)) begin
            badCnt++;
            $display("[TB] FAIL %s abort-results got err=%0d fval=%b fev=%0d want err=%0d fval=%b fev=%0d",
                     tag, obsErr, obsFval, obsFev, expErr, gotFirst, firstV);
          end
          tick();
          tick();
          totalCnt++;
          if (obsBusy !== 1'b0 || obsDone !== 1'b0 || obsVec !== 16'(v)) begin
            badCnt++;
            $display("[TB] FAIL %s post-abort-idle got busy=%b done=%b vec=%0d want busy=0 done=0 vec=%0d",
                     tag, obsBusy, obsDone, obsVec, v);
          end
          return;
        end
        totalCnt++;
        if (obsVec !== 16'(v) || obsBusy !== 1'b1 || obsDone !== 1'b0) begin
          badCnt++;
          $display("[TB] FAIL %s vec-hold v=%0d c=%0d got vec=%0d busy=%b done=%b want vec=%0d busy=1 done=0",
                   tag, v, c, obsVec, obsBusy, obsDone, v);
        end
        tick();
      end
    end

    totalCnt++;
    if (obsDone !== 1'b1 || obsBusy !== 1'b0) begin
      badCnt++;
      $display("[TB] FAIL %s done-edge got done=%b busy=%b want done=1 busy=0", tag, obsDone, obsBusy);
    end
    totalCnt++;
    if (obsErr !== 16'(expErr) || obsPass !== (expErr == 0)) begin
      badCnt++;
      $display("[TB] FAIL %s result got err=%0d pass=%b want err=%0d pass=%b",
               tag, obsErr, obsPass, expErr, (expErr == 0));
    end
    totalCnt++;
    if (obsFval !== gotFirst || obsFev !== 16'(firstV)) begin
      badCnt++;
      $display("[TB] FAIL %s first-err got fval=%b fev=%0d want fval=%b fev=%0d",
               tag, obsFval, obsFev, gotFirst, firstV);
    end
    tick();
    totalCnt++;
    if (obsDone !== 1'b0 || obsPass !== (expErr == 0) || obsVec !== 16'(total - 1)) begin
      badCnt++;
      $display("[TB] FAIL %s done-hold got done=%b pass=%b vec=%0d want done=0 pass=%b vec=%0d",
               tag, obsDone, obsPass, obsVec, (expErr == 0), total - 1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    for (int s = 0; s < 2; s++) begin
      selectDut(s);
      totalCnt++;
      if (obsVec !== 16'd0 || obsErr !== 16'd0 || obsFev !== 16'd0 || obsBusy !== 1'b0 ||
          obsDone !== 1'b0 || obsPass !== 1'b0 || obsFval !== 1'b0) begin
        badCnt++;
        $display("[TB] FAIL reset dut=%0d got vec=%0d err=%0d fev=%0d busy=%b done=%b pass=%b fval=%b want all 0",
                 s, obsVec, obsErr, obsFev, obsBusy, obsDone, obsPass, obsFval);
      end
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_and_pass();
    selectDut(0);
    mode = 2'b00;
    en   = 16'h0007;
    fillResp(0);
    runSweep("and_pass", -1, 0, 1'b0);
    totalCnt++;
    if (obsErr !== 16'd0 || obsPass !== 1'b1 || obsFval !== 1'b0) begin
      badCnt++;
      $display("[TB] FAIL and_pass const got err=%0d pass=%b fval=%b want 0 1 0", obsErr, obsPass, obsFval);
    end
  endtask

  task automatic test_xor_wrong();
    selectDut(0);
    mode = 2'b10;
    en   = 16'h0005;
    fillResp(1);
    runSweep("xor_wrong", -1, 0, 1'b0);
    totalCnt++;
    if (obsErr !== 16'd4 || obsFev !== 16'd2 || obsPass !== 1'b0) begin
      badCnt++;
      $display("[TB] FAIL xor_wrong const got err=%0d fev=%0d pass=%b want 4 2 0", obsErr, obsFev, obsPass);
    end
  endtask

  task automatic test_nand_stuck();
    selectDut(1);
    mode = 2'b11;
    en   = 16'h0003;
    fillResp(2);
    runSweep("nand_stuck", -1, 0, 1'b0);
    totalCnt++;
    if (obsErr !== 16'd1 || obsFev !== 16'd3) begin
      badCnt++;
      $display("[TB] FAIL nand_stuck const got err=%0d fev=%0d want 1 3", obsErr, obsFev);
    end
  endtask

  task automatic test_saturate();
    selectDut(1);
    mode = 2'b00;
    en   = 16'h0003;
    fillResp(3);
    runSweep("saturate", -1, 0, 1'b0);
    totalCnt++;
    if (obsErr !== 16'd3 || obsFev !== 16'd0 || obsFval !== 1'b1) begin
      badCnt++;
      $display("[TB] FAIL saturate const got err=%0d fev=%0d fval=%b want 3 0 1", obsErr, obsFev, obsFval);
    end
  endtask

  task automatic test_abort();
    selectDut(0);
    mode = 2'b00;
    en   = 16'h0007;
    fillResp(3);
    runSweep("abort_v5", 5, curS, 1'b0);
    totalCnt++;
    if (obsErr !== 16'd5 || obsVec !== 16'd5 || obsDone !== 1'b0) begin
      badCnt++;
      $display("[TB] FAIL abort_v5 const got err=%0d vec=%0d done=%b want 5 5 0", obsErr, obsVec, obsDone);
    end
    mode = 2'b01;
    en   = 16'h0007;
    fillResp(0);
    runSweep("abort_restart", -1, 0, 1'b0);
  endtask

  task automatic test_reset_midsweep();
    selectDut(0);
    mode = 2'b00;
    en   = 16'h0007;
    fillResp(3);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    totalCnt++;
    if (obsVec !== 16'd0 || obsErr !== 16'd0 || obsFev !== 16'd0 || obsBusy !== 1'b0 ||
        obsDone !== 1'b0 || obsPass !== 1'b0 || obsFval !== 1'b0) begin
      badCnt++;
      $display("[TB] FAIL midsweep_reset got vec=%0d err=%0d fev=%0d busy=%b done=%b pass=%b fval=%b want all 0",
               obsVec, obsErr, obsFev, obsBusy, obsDone, obsPass, obsFval);
    end
    for (int i = 0; i < 6; i++) tick();
    totalCnt++;
    if (obsBusy !== 1'b0 || obsVec !== 16'd0 || obsDone !== 1'b0) begin
      badCnt++;
      $display("[TB] FAIL midsweep_stays_idle got busy=%b vec=%0d done=%b want 0 0 0", obsBusy, obsVec, obsDone);
    end
    mode = 2'b00;
    en   = 16'h0007;
    fillResp(4);
    runSweep("after_reset", -1, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    selectDut(1);
    mode = 2'b01;
    en   = 16'h0002;
    fillResp(4);
    runSweep("b2b_first", -1, 0, 1'b0);
    mode = 2'b10;
    en   = 16'h0003;
    fillResp(4);
    runSweep("b2b_start_abort", -1, 0, 1'b1);
  endtask

  task automatic test_random();
    int total;
    int av;
    int ap;
    for (int it = 0; it < 12; it++) begin
      selectDut(int'($urandom_range(0, 1)));
      mode = 2'($urandom_range(0, 3));
      en   = 16'($urandom);
      if ($urandom_range(0, 5) == 0) en = 16'h0000;
      fillResp(int'($urandom_range(0, 4)));
      total = 1 << curN;
      av = -1;
      ap = 0;
      if ($urandom_range(0, 2) == 0) begin
        av = int'($urandom_range(0, total - 1));
        ap = int'($urandom_range(0, curS));
      end
      runSweep($sformatf("rand%0d", it), av, ap, 1'b0);
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    mode  = 2'b00;
    en    = 16'h0000;
    for (int i = 0; i < 16; i++) respTable[i] = 1'b0;
    selectDut(0);
    test_reset();
    test_and_pass();
    test_xor_wrong();
    test_nand_stuck();
    test_saturate();
    test_abort();
    test_reset_midsweep();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
    $finish;
  end

endmodule
